// File: rtl/enemy_bullet_pool.sv
// Alien projectile pool: schedules fire attempts, queries the fleet for a shooter,
// moves bullets once per frame, kills them at the bottom or on the paddle, and draws them.
module enemy_bullet_pool #(
    parameter int          NUM_BULLETS = 4,
    parameter int          FIRE_PERIOD = 48,
    parameter int          EB_SPEED    = 8,
    parameter int          HRES        = 1280,
    parameter int          VRES        = 720,
    parameter int          BULLET_W    = 4,
    parameter int          BULLET_H    = 16,
    parameter int          PADDLE_W    = 50,
    parameter int          PADDLE_H    = 20,
    parameter int          ENEMY_W     = 32,
    parameter int          ENEMY_H     = 28,
    parameter int          NUM_COLS    = 10,
    parameter logic [23:0] EB_COLOR    = 24'hFF0000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        frame_tick,
    input  logic        game_active,
    input  logic [10:0] paddle_x,
    output logic        col_req,
    output logic [3:0]  col_idx,
    input  logic        col_rsp,
    input  logic        col_alive,
    input  logic [10:0] shooter_x,
    input  logic [9:0]  shooter_y,
    output logic        player_hit,
    input  logic [10:0] sx,
    input  logic [9:0]  sy,
    output logic        pix_on,
    output logic [23:0] pix_rgb
);
    localparam int               CNT_W     = $clog2(FIRE_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FIRE_PERIOD - 1);
    localparam logic [10:0]      SPAWN_DX  = 11'((ENEMY_W - BULLET_W) / 2);
    localparam logic [10:0]      SPAWN_DY  = 11'(ENEMY_H);
    localparam logic [11:0]      SPEED12   = 12'(EB_SPEED);
    localparam logic [11:0]      VRES12    = 12'(VRES);
    localparam logic [11:0]      HRES12    = 12'(HRES);
    localparam logic [11:0]      PAD_TOP12 = 12'(VRES - PADDLE_H);
    localparam logic [11:0]      PAD_W12   = 12'(PADDLE_W);
    localparam logic [11:0]      BW12      = 12'(BULLET_W);
    localparam logic [11:0]      BH12      = 12'(BULLET_H);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       frame_cnt_reg, frame_cnt_next;
    logic [3:0]             col_idx_reg, col_idx_next;
    logic [7:0]             lfsr_reg;
    logic                   player_hit_reg;
    logic                   pix_on_reg;
    logic                   spawn_en;

    logic [NUM_BULLETS-1:0] act_vec;
    logic [NUM_BULLETS-1:0] free_vec;
    logic [NUM_BULLETS-1:0] spawn_sel;
    logic [NUM_BULLETS-1:0] hit_vec;
    logic [NUM_BULLETS-1:0] cover_vec;

    logic [11:0]            sx12, sy12, paddle12;

    assign sx12     = {1'b0, sx};
    assign sy12     = {2'b00, sy};
    assign paddle12 = {1'b0, paddle_x};

    // Free-running column picker; keeps stepping even while the game is halted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
        end
    end

    // Isolate the lowest free slot so a spawn always fills from index 0 upward.
    assign free_vec  = ~act_vec;
    assign spawn_sel = free_vec & (~free_vec + NUM_BULLETS'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            frame_cnt_reg <= '0;
            col_idx_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            frame_cnt_reg <= frame_cnt_next;
            col_idx_reg   <= col_idx_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        col_idx_next   = col_idx_reg;
        spawn_en       = 1'b0;
        if (!game_active) begin
            state_next     = IDLE;
            frame_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (frame_tick) begin
                        if (frame_cnt_reg == CNT_MAX) begin
                            // With the pool full the counter stays saturated, so every later tick retries.
                            if (|free_vec) begin
                                state_next     = REQ;
                                frame_cnt_next = '0;
                                col_idx_next   = 4'(lfsr_reg % 8'(NUM_COLS));
                            end
                        end else begin
                            frame_cnt_next = frame_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                REQ: begin
                    if (col_rsp) begin
                        state_next = IDLE;
                        spawn_en   = col_alive;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
        logic        act_reg, act_next;
        logic [10:0] x_reg, x_next;
        logic [10:0] y_reg, y_next;
        logic [11:0] x12, y12, y_step;
        logic        written, move, at_bottom, in_paddle_rows, over_paddle;

        assign x12            = {1'b0, x_reg};
        assign y12            = {1'b0, y_reg};
        assign y_step         = y12 + SPEED12;
        assign written        = spawn_en && spawn_sel[gi];
        assign move           = frame_tick && act_reg && !written;
        assign at_bottom      = y_step >= VRES12;
        assign in_paddle_rows = (y_step + BH12) > PAD_TOP12;
        assign over_paddle    = (x12 < paddle12 + PAD_W12) && (x12 + BW12 > paddle12);
        assign hit_vec[gi]    = move && !at_bottom && in_paddle_rows && over_paddle;
        assign act_vec[gi]    = act_reg;
        assign cover_vec[gi]  = act_reg && (sx12 < HRES12)
                                && (sx12 >= x12) && (sx12 < x12 + BW12)
                                && (sy12 >= y12) && (sy12 < y12 + BH12);

        always_comb begin
            act_next = act_reg;
            x_next   = x_reg;
            y_next   = y_reg;
            if (!game_active) begin
                act_next = 1'b0;
            end else if (written) begin
                act_next = 1'b1;
                x_next   = shooter_x + SPAWN_DX;
                y_next   = {1'b0, shooter_y} + SPAWN_DY;
            end else if (move) begin
                if (at_bottom || hit_vec[gi]) begin
                    act_next = 1'b0;
                end else begin
                    y_next = y_step[10:0];
                end
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                act_reg <= 1'b0;
                x_reg   <= '0;
                y_reg   <= '0;
            end else begin
                act_reg <= act_next;
                x_reg   <= x_next;
                y_reg   <= y_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            player_hit_reg <= 1'b0;
            pix_on_reg     <= 1'b0;
        end else begin
            player_hit_reg <= game_active && (|hit_vec);
            // Gated so a halted game never flashes the bullets it is about to clear.
            pix_on_reg     <= game_active && (|cover_vec);
        end
    end

    assign col_req    = (state_reg == REQ);
    assign col_idx    = col_idx_reg;
    assign player_hit = player_hit_reg;
    assign pix_on     = pix_on_reg;
    assign pix_rgb    = pix_on_reg ? EB_COLOR : 24'h000000;

endmodule
